// File: rtl/pmem_responder.sv
// Line-granular backing store behind the L2 pmem port: one request at a time,
// fixed LATENCY from acceptance to a single-cycle pmem_resp.
module pmem_responder #(
    parameter int LATENCY   = 4,
    parameter int LOG_LINES = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         busy,
    output logic         protocol_err
);

    localparam int LINES = 1 << LOG_LINES;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [LOG_LINES-1:0] line_index(input logic [15:0] addr);
        return addr[LOG_LINES+3:4];
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 accept;

    // Request captured at acceptance; held until the FSM is back in IDLE.
    logic                 op_write_p0;
    logic [LOG_LINES-1:0] idx_p0;
    logic [127:0]         wdata_p0;

    // Operation as seen by the edge that enters RESP; with LATENCY=1 that is
    // the acceptance edge itself, so the live inputs must be used there.
    logic                 cur_write;
    logic [LOG_LINES-1:0] cur_idx;

    logic [127:0]         mem [LINES] = '{default: '0};

    logic                 unused_addr_bits;
    assign unused_addr_bits = ^pmem_address;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        cur_write = op_write_p0;
        cur_idx   = idx_p0;
        if (state_q == IDLE) begin
            cur_write = pmem_write;
            cur_idx   = line_index(pmem_address);
        end
    end

    // Stage p0: capture of the accepted request (data only, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write_p0 <= pmem_write;
            idx_p0      <= line_index(pmem_address);
            wdata_p0    <= pmem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pmem_resp    <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
            pmem_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pmem_resp <= (state_d == RESP);
            busy      <= (state_d != IDLE);
            if (state_q == IDLE && pmem_read && pmem_write) begin
                protocol_err <= 1'b1;
            end
            if (state_d == RESP && state_q != RESP && !cur_write) begin
                pmem_rdata <= mem[cur_idx];
            end
        end
    end

    // Commit on the edge leaving RESP; an async reset forces IDLE first,
    // which discards any captured but uncommitted write.
    always_ff @(posedge clk) begin
        if (state_q == RESP && op_write_p0) begin
            mem[idx_p0] <= wdata_p0;
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: LATENCY=4 and LATENCY=1 instances share
// the request bus; a reference line store and an expected-data queue check reads.
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd, wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    bit           sel;

    logic [127:0] rdata4, rdata1;
    logic         resp4, resp1, busy4, busy1, err4, err1;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] model [int];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(4), .LOG_LINES(12)) dut (
        .clk(clk), .reset(reset),
        .pmem_read(rd & ~sel), .pmem_write(wr & ~sel),
        .pmem_address(addr), .pmem_wdata(wdata),
        .pmem_rdata(rdata4), .pmem_resp(resp4), .busy(busy4), .protocol_err(err4)
    );

    pmem_responder #(.LATENCY(1), .LOG_LINES(12)) dut1 (
        .clk(clk), .reset(reset),
        .pmem_read(rd & sel), .pmem_write(wr & sel),
        .pmem_address(addr), .pmem_wdata(wdata),
        .pmem_rdata(rdata1), .pmem_resp(resp1), .busy(busy1), .protocol_err(err1)
    );

    wire [127:0] rdata = sel ? rdata1 : rdata4;
    wire         resp  = sel ? resp1  : resp4;
    wire         busy  = sel ? busy1  : busy4;
    wire         perr  = sel ? err1   : err4;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int key_of(input logic [15:0] a);
        return {19'd0, sel, a[15:4]};
    endfunction

    function automatic logic [127:0] model_rd(input int k);
        if (model.exists(k)) return model[k];
        return '0;
    endfunction

    // Called at a negedge; drives the request immediately and returns at the
    // negedge of the IDLE cycle that follows RESP.
    task automatic do_req(input string tag, input bit r, input bit w,
                          input logic [15:0] a, input logic [127:0] d, input bit disturb);
        int lat = sel ? 1 : 4;
        int first_k = -1;
        int nresp = 0;
        bit popped = 0;
        logic [7:0] bmask = '0;
        logic [7:0] bexp;
        logic [127:0] e;
        if (w) model[key_of(a)] = d;
        else exp_q.push_back(model_rd(key_of(a)));
        rd = r; wr = w; addr = a; wdata = d;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            bmask[k] = busy;
            if (resp) begin
                nresp++;
                if (first_k < 0) first_k = k;
                if (!w && !popped) begin
                    e = exp_q.pop_front();
                    popped = 1;
                    check({tag, "_rdata"}, rdata, e);
                end
            end
            if (disturb && k == 1) begin
                addr = a ^ 16'h0010;
                wdata = ~d;
            end
            if (disturb && k == lat - 1) wr = 1'b0;
            if (k == lat) begin rd = 1'b0; wr = 1'b0; end
        end
        if (!w && !popped) void'(exp_q.pop_front());
        bexp = 8'((1 << (lat + 1)) - 2);
        check({tag, "_resp_cycle"}, 128'(first_k), 128'(lat));
        check({tag, "_resp_pulses"}, 128'(nresp), 128'd1);
        check({tag, "_busy_mask"}, 128'(bmask), 128'(bexp));
    endtask

    localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D2 = 128'hA0A0_A0A0_0101_0101_5A5A_5A5A_C3C3_C3C3;
    localparam logic [127:0] D3 = 128'h0BAD_F00D_0BAD_F00D_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D4 = 128'hFEDC_BA98_7654_3210_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] D5 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    initial begin
        int seen;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp", 128'(resp4), 128'd0);
        check("rst_busy", 128'(busy4), 128'd0);
        check("rst_perr", 128'(err4), 128'd0);
        check("rst_rdata", rdata4, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        do_req("wr_0040", 1'b0, 1'b1, 16'h0040, D0, 1'b0);
        do_req("rd_004F", 1'b1, 1'b0, 16'h004F, '0, 1'b0);
        do_req("rd_1230", 1'b1, 1'b0, 16'h1230, '0, 1'b0);

        do_req("both_0080", 1'b1, 1'b1, 16'h0080, D1, 1'b0);
        check("perr_set", 128'(perr), 128'd1);
        do_req("rd_0080", 1'b1, 1'b0, 16'h0080, '0, 1'b0);
        check("perr_sticky", 128'(perr), 128'd1);

        // Abort a write to 0x00A0 with reset two cycles in.
        do_req("wr_00A0_old", 1'b0, 1'b1, 16'h00A0, D2, 1'b0);
        rd = 1'b0; wr = 1'b1; addr = 16'h00A0; wdata = D3;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp) seen++;
        end
        reset = 1'b1; wr = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_resp", 128'(resp), 128'd0);
        check("abort_perr_cleared", 128'(perr), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp) seen++;
        end
        check("abort_no_resp", 128'(seen), 128'd0);
        do_req("rd_00A0", 1'b1, 1'b0, 16'h00A0, '0, 1'b0);

        // Inputs changed mid-WAIT and write dropped before the response.
        do_req("wr_00C0_dist", 1'b0, 1'b1, 16'h00C0, D4, 1'b1);
        do_req("rd_00C0", 1'b1, 1'b0, 16'h00C0, '0, 1'b0);
        do_req("rd_00D0", 1'b1, 1'b0, 16'h00D0, '0, 1'b0);

        sel = 1'b1;
        @(negedge clk);
        do_req("l1_rd_0310", 1'b1, 1'b0, 16'h0310, '0, 1'b0);
        do_req("l1_wr_0300", 1'b0, 1'b1, 16'h0300, D5, 1'b0);
        do_req("l1_rd_0307", 1'b1, 1'b0, 16'h0307, '0, 1'b0);
        check("l1_perr", 128'(perr), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Physical-memory responder for the L2 cache's `pmem_*` port: it is the memory-side end of the line-fill and write-back protocol that the L2 datapath and controller initiate. It holds a line-granular backing store of 128-bit blocks. It accepts one read or write request at a time, holds the request for a fixed, parameterised latency, and then returns a single-cycle `pmem_resp`, with read data when the request was a read. It sits below the L2 cache in the memory hierarchy and is used both as the synthesizable memory model for system simulation and as the stall-accurate stand-in for DRAM.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`. Legal range is 1 or more.
- `LOG_LINES`, default 12: log2 of the number of 128-bit lines stored.
- `clk` in, 1 bit: clock. Every register updates on the rising edge.
- `reset` in, 1 bit: reset, asynchronous, active-high.
- `pmem_read` in, 1 bit: read request. The requester holds it high until it sees `pmem_resp`.
- `pmem_write` in, 1 bit: write request. Same hold rule as `pmem_read`.
- `pmem_address` in, 16 bits: byte address. Bits [3:0] are ignored. Bits [LOG_LINES+3:4] select the line. Higher bits are ignored, so those addresses alias.
- `pmem_wdata` in, 128 bits (`lc3b_block`): write line data.
- `pmem_rdata` out, 128 bits: read line data. Valid whenever `pmem_resp` is high for a read.
- `pmem_resp` out, 1 bit: single-cycle completion pulse.
- `busy` out, 1 bit: high while a request is accepted but not yet completed, including the response cycle.
- `protocol_err` out, 1 bit: sticky. Set when `pmem_read` and `pmem_write` are seen high together in IDLE.

## Operation
- FSM has three states.
  - IDLE: no request in progress.
  - WAIT: down-counter `cnt` (width `$clog2(LATENCY+1)`) is counting.
  - RESP: `pmem_resp` is high for exactly this one cycle.
- Acceptance: a request is accepted on the edge that ends an IDLE cycle in which `pmem_read | pmem_write` is high.
  - On that edge, capture the op, line index, and `pmem_wdata`.
  - Inputs after acceptance are ignored until the FSM returns to IDLE.
- Transitions:
  - IDLE to WAIT, with `cnt` = LATENCY-1, when LATENCY > 1.
  - IDLE to RESP directly when LATENCY = 1.
  - WAIT decrements `cnt` each cycle. WAIT goes to RESP on the edge where `cnt` = 1.
  - RESP always returns to IDLE.
  - No back-to-back acceptance: the earliest next acceptance is the edge ending the IDLE cycle that follows RESP.
- Read:
  - `pmem_rdata` is loaded from `mem[idx]` on the edge entering RESP.
  - It then holds that value until the next read enters RESP. Writes never change `pmem_rdata`.
- Write:
  - `mem[idx]` is written with the captured data on the edge leaving RESP.
  - A read accepted immediately afterwards returns the new data.
- Simultaneous read and write in IDLE: the request is treated as a write, the read is dropped, and `protocol_err` is set.
- Requester drops its request mid-WAIT: the transaction still completes, including the memory update for a write, and `pmem_resp` is still pulsed.

## Timing
- Reset values: `pmem_resp`=0, `busy`=0, `protocol_err`=0, `pmem_rdata`=0, state IDLE, `cnt`=0.
- Reset has no effect on the memory array.
  - The array initialises to all-zero at time 0.
  - Contents survive every later reset.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and `pmem_resp` goes low.
  - A captured but uncommitted write is discarded, and memory is unchanged.
  - The first request after reset deasserts takes the full LATENCY.
- Latency: if a request is first visible in cycle T and the FSM is in IDLE, `pmem_resp` is high in cycle T+LATENCY only.
  - `busy` is high in cycles T+1 through T+LATENCY.
  - Request-to-request period is LATENCY+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x0040 with LATENCY=4 → `pmem_resp` is high in cycle T+4 only, and `busy` is high in cycles T+1..T+4.
- Read 0x004F immediately after that write → `pmem_rdata` equals the written line in the response cycle, and offset bits [3:0] are ignored.
- Read a never-written line 0x1230 → `pmem_rdata`=0. Then do a write followed by a read of the same line at LATENCY=1 → response one cycle after each acceptance, and the read returns the written data.
- Raise `pmem_read` and `pmem_write` together on address 0x0080 → the write is performed, `protocol_err` goes to 1 and stays at 1. A subsequent read of 0x0080 returns the write data.
- Assert `reset` two cycles into a write to 0x00A0 → `pmem_resp` is never pulsed and `busy` goes to 0. A later read of 0x00A0 returns the old contents.
- Change `pmem_address` and `pmem_wdata` during WAIT, and drop `pmem_write` one cycle before the response → the captured line at the originally captured address is written, and `pmem_resp` is still pulsed once.
